// File: rtl/m14k_ic_mbist_march.sv
// m14k_ic_mbist_march: March C- BIST sequencer that owns one I-cache SRAM port while running.
// Ports: gclk_i/greset_i clock and sync active-high reset; bist_start_i/bist_abort_i run control;
//   bist_busy_o/bist_done_o/bist_fail_o status; bist_fail_addr_o/bist_fail_elem_o first-miscompare capture;
//   ram_en_o/ram_wr_o/ram_addr_o/ram_wdata_o registered array port; ram_rdata_i read data one cycle after a read.
module m14k_ic_mbist_march #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  gclk_i,
  input  logic                  greset_i,
  input  logic                  bist_start_i,
  input  logic                  bist_abort_i,
  output logic                  bist_busy_o,
  output logic                  bist_done_o,
  output logic                  bist_fail_o,
  output logic [ADDR_WIDTH-1:0] bist_fail_addr_o,
  output logic [2:0]            bist_fail_elem_o,
  output logic                  ram_en_o,
  output logic                  ram_wr_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2, ST_DONE = 2'd3;
  localparam logic [ADDR_WIDTH-1:0] A_MAX = '1;
  logic [1:0] state_q, state_d;
  logic [2:0] elem_q, elem_d, elem_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic ph_q, ph_d;
  logic two_ph, dn_cur, dn_nx, last_a, start, mis;
  logic en_q, en_d, wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic busy_q, busy_d, done_q, done_d;
  logic chk_v_q, chk_v_d, chk_exp_q, chk_exp_d;
  logic [ADDR_WIDTH-1:0] chk_addr_q, chk_addr_d;
  logic [2:0] chk_elem_q, chk_elem_d;
  logic fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0] fail_elem_q, fail_elem_d;
  // Counters name the operation currently on the array port; port flops load from their next value.
  always_comb begin
    two_ph  = (elem_q != 3'd0) && (elem_q != 3'd5);
    dn_cur  = (elem_q == 3'd3) || (elem_q == 3'd4);
    elem_nx = elem_q + 3'd1;
    dn_nx   = (elem_nx == 3'd3) || (elem_nx == 3'd4);
    last_a  = dn_cur ? (addr_q == '0) : (addr_q == A_MAX);
    start   = bist_start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    state_d = state_q;
    elem_d  = elem_q;
    addr_d  = addr_q;
    ph_d    = ph_q;
    if (bist_abort_i) state_d = ST_IDLE;
    else if (start) begin
      state_d = ST_RUN;
      elem_d  = 3'd0;
      addr_d  = '0;
      ph_d    = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (elem_q == 3'd5 && addr_q == A_MAX) state_d = ST_DRAIN;
      else if (two_ph && !ph_q) ph_d = 1'b1;
      else begin
        ph_d   = 1'b0;
        elem_d = last_a ? elem_nx : elem_q;
        addr_d = last_a ? (dn_nx ? A_MAX : '0) : (dn_cur ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1));
      end
    end else if (state_q == ST_DRAIN) state_d = ST_DONE;
    en_d    = state_d == ST_RUN;
    wr_d    = en_d && (elem_d == 3'd0 || ph_d);
    raddr_d = en_d ? addr_d : '0;
    wdata_d = {DATA_WIDTH{wr_d && (elem_d == 3'd1 || elem_d == 3'd3)}};
    busy_d  = state_d == ST_RUN || state_d == ST_DRAIN;
    done_d  = state_d == ST_DONE;
    chk_v_d    = !bist_abort_i && state_q == ST_RUN && en_q && !wr_q;
    chk_exp_d  = elem_q == 3'd2 || elem_q == 3'd4;
    chk_addr_d = addr_q;
    chk_elem_d = elem_q;
    mis = chk_v_q && !bist_abort_i && (ram_rdata_i != {DATA_WIDTH{chk_exp_q}});
    fail_d      = (start && !bist_abort_i) ? 1'b0 : fail_q || mis;
    fail_addr_d = (start && !bist_abort_i) ? '0 : (mis && !fail_q) ? chk_addr_q : fail_addr_q;
    fail_elem_d = (start && !bist_abort_i) ? '0 : (mis && !fail_q) ? chk_elem_q : fail_elem_q;
  end
  always_ff @(posedge gclk_i) begin
    if (greset_i) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      ph_q        <= 1'b0;
      en_q        <= 1'b0;
      wr_q        <= 1'b0;
      raddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      chk_v_q     <= 1'b0;
      chk_exp_q   <= 1'b0;
      chk_addr_q  <= '0;
      chk_elem_q  <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      ph_q        <= ph_d;
      en_q        <= en_d;
      wr_q        <= wr_d;
      raddr_q     <= raddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      chk_v_q     <= chk_v_d;
      chk_exp_q   <= chk_exp_d;
      chk_addr_q  <= chk_addr_d;
      chk_elem_q  <= chk_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end
  assign bist_busy_o      = busy_q;
  assign bist_done_o      = done_q;
  assign bist_fail_o      = fail_q;
  assign bist_fail_addr_o = fail_addr_q;
  assign bist_fail_elem_o = fail_elem_q;
  assign ram_en_o         = en_q;
  assign ram_wr_o         = wr_q;
  assign ram_addr_o       = raddr_q;
  assign ram_wdata_o      = wdata_q;
endmodule

// File: doc/m14k_ic_mbist_march.md
Name: m14k_ic_mbist_march

Overview:
- March C- memory-BIST sequencer for one I-cache SRAM array (tag, way-select or data).
- Replaces the tie-off BIST controller path for that array. It takes over the array's single read/write port while active, then reports pass/fail plus the first failing address and element.
- One instance per array. The top-level cache BIST interface drives bist_start and bist_abort and collects the status outputs.

Parameters:
- ADDR_WIDTH, 8, array address width; N = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, array word width.

Ports:
- gclk  input  1  core clock.
- greset  input  1  synchronous active-high reset.
- bist_start  input  1  run request; sampled in IDLE and DONE only.
- bist_abort  input  1  terminate the run and return to IDLE.
- bist_busy  output  1  controller owns the array port.
- bist_done  output  1  run complete; held high until next start or reset.
- bist_fail  output  1  sticky miscompare flag.
- bist_fail_addr  output  ADDR_WIDTH  address of the first miscompare.
- bist_fail_elem  output  3  March element (0-5) of the first miscompare.
- ram_en  output  1  array access enable.
- ram_wr  output  1  1=write, 0=read (valid when ram_en=1).
- ram_addr  output  ADDR_WIDTH  array address.
- ram_wdata  output  DATA_WIDTH  write data; all-0s or all-1s.
- ram_rdata  input  DATA_WIDTH  read data, valid the cycle after the read.

Behaviour:
- Clock and reset: one clock, gclk. greset is synchronous and active-high.
- Reset state: all outputs 0; state IDLE; fail capture registers cleared.
- March elements, with backgrounds D0 = {DATA_WIDTH{0}} and D1 = {DATA_WIDTH{1}}:
  - E0 up(w0).
  - E1 up(r0,w1).
  - E2 up(r1,w0).
  - E3 down(r0,w1).
  - E4 down(r1,w0).
  - E5 up(r0).
- Address order: "up" runs 0..N-1; "down" runs N-1..0.
- Operation cost: one array operation per cycle, with no idle cycles between operations or elements. Total 10N operations.
- Element sequencing: within E1-E4, the read and write to the same address occur on consecutive cycles, read first.
- Sequencer state: ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE. In ST_RUN it tracks the element counter (3b), the address counter (ADDR_WIDTH) and the op-phase bit.
- Transitions:
  - IDLE or DONE, with bist_start=1 and bist_abort=0 → RUN. This clears bist_fail, bist_fail_addr, bist_fail_elem and bist_done.
  - RUN, after the last E5 read issues → DRAIN (one cycle, for the final compare) → DONE.
  - Any state, with bist_abort=1 → IDLE. This forces ram_en=0 and bist_busy=0 next cycle; bist_done stays 0 and the fail registers keep their current values.
- Timing, with start sampled at the end of cycle 0:
  - ram_en=1 in cycles 1..10N.
  - bist_busy=1 in cycles 1..10N+1.
  - bist_done=1 from cycle 10N+2.
- Address wrap: the address counter wraps between elements (N-1 → 0 or 0 → N-1 as the next element requires). No extra cycle is spent.
- Compare pipeline: a read issued in cycle k registers its expected value, address and element. ram_rdata is compared in cycle k+1. On a miscompare, bist_fail is set and visible in cycle k+2.
- Fail capture: only the first miscompare loads bist_fail_addr and bist_fail_elem; later miscompares leave them unchanged. The run always completes; there is no stop-on-fail.
- bist_start while busy is ignored. bist_start and bist_abort asserted together → abort wins.
- greset mid-run returns to IDLE with every output 0 on the next cycle.
- Outputs are registered; ram_* are driven only from flops.
- Write data: ram_wdata=0 whenever ram_en=0 or ram_wr=0.

Test Plan:
- Clean run: ADDR_WIDTH=3 (N=8), fault-free model, start at cycle 0. Required: 80 operations, address order 0..7 / 7..0 exactly as the March definition, bist_done=1 at cycle 82, bist_fail=0.
- Stuck-at-1 on bit 4 at address 5. Required: bist_fail=1, bist_fail_addr=5, bist_fail_elem=1; bist_done still at cycle 82.
- Transition fault: address 2 bit 0 cannot rise 0→1. Required: first fail elem=2, addr=2; later fails in E4 do not overwrite the capture.
- Abort: bist_abort at cycle 30. Required: cycle 31 has ram_en=0, bist_busy=0, bist_done=0. A restart at cycle 40 gives done at cycle 40+82.
- Start during run and reset during run:
  - bist_start pulses at cycles 10 and 20 have no effect on the sequence.
  - greset at cycle 50 gives all outputs 0 at cycle 51. A new start then runs a full, clean 80-op sequence.
- Back-to-back runs: start again while in DONE with the previous run failed. Required: fail flags clear in the cycle after start; the fault-free second run ends with bist_fail=0.
